aes_round_sequencer: RTL
========================

// Module: aes_round_sequencer
// PURPOSE
//  Control FSM for the iterative AES encrypt datapath. It sequences key
//  expansion, then one AddRoundKey-only round plus Nr full/last rounds per
//  block, and drives the datapath round mux, state-register load and
//  first/last selects. Valid/ready handshakes on the block input and output.
//  Sits between the SPI front end and the round datapath/key expander.
// PARAMETERS
//  Nr              14  number of rounds (10/12/14 for Nk=4/6/8)
//  KEY_EXP_CYCLES  15  cycles the key expander needs after its reset pulse
// PORTS
//  clk         in   1  clock, all state on rising edge
//  rst         in   1  asynchronous, active-low reset
//  key_valid   in   1  new key present on key bus; starts (re)expansion
//  key_ready   out  1  expanded schedule valid; blocks may be accepted
//  expand_rst  out  1  one-cycle active-high reset pulse to key expander
//  blk_valid   in   1  input block available
//  blk_ready   out  1  sequencer accepts block (handshake = valid&ready)
//  round_idx   out  4  round-key select to datapath, 0..Nr
//  sel_first   out  1  datapath uses in^w[0] path (round_idx==0)
//  sel_last    out  1  datapath uses no-MixColumns path (round_idx==Nr)
//  state_load  out  1  capture enable for datapath state register
//  out_valid   out  1  ciphertext on datapath output is final
//  out_ready   in   1  consumer takes ciphertext (handshake = valid&ready)
//  busy        out  1  high in S_EXPAND or S_ROUND
// BEHAVIOUR
//  Reset (rst=0, async): state=S_IDLE, exp_cnt=0, round_idx=0; every output
//   0. Outputs registered except blk_ready (see below).
//  States: S_IDLE, S_EXPAND, S_WAIT, S_ROUND, S_HOLD.
//  key_valid sampled high in any state -> next cycle expand_rst=1,
//   exp_cnt=0, state=S_EXPAND, key_ready=0. Priority over all else: an
//   in-flight block is dropped, out_valid cleared, no output produced.
//  S_EXPAND: exp_cnt increments each cycle; at exp_cnt==KEY_EXP_CYCLES-1
//   -> S_WAIT, key_ready=1. key_ready first high KEY_EXP_CYCLES+1 cycles
//   after the edge sampling key_valid.
//  S_IDLE: waits for key_valid only; blk_valid ignored.
//  S_WAIT: blk_ready = (state==S_WAIT) & ~key_valid (comb). On handshake
//   -> S_ROUND, round_idx=0, state_load=1, sel_first=1.
//  S_ROUND: state_load=1 every cycle; round_idx increments 0..Nr, one per
//   cycle; sel_first iff round_idx==0, sel_last iff round_idx==Nr. After
//   the round_idx==Nr cycle -> S_HOLD, out_valid=1, state_load=0.
//  Latency: handshake edge T; rounds occupy T+1..T+Nr+1; out_valid high
//   from T+Nr+2. Throughput: one block per Nr+3 cycles min.
//  S_HOLD: out_valid held, round_idx frozen at Nr, state_load=0 (result
//   stable) until out_ready sampled high -> S_WAIT, out_valid=0 next
//   cycle. No new block accepted in S_HOLD (no overlap).
//  round_idx never exceeds Nr; no wrap. exp_cnt saturates in S_WAIT.
//  key_valid held high: expansion restarts every cycle, key_ready stays 0.
// TESTING
//  1. Reset low mid-S_ROUND (round_idx=7) -> all outputs 0 immediately,
//     S_IDLE; blk_valid=1 afterwards -> blk_ready stays 0.
//  2. key_valid 1 cycle at edge 0 -> expand_rst=1 at cycle 1 only;
//     key_ready=1 at cycle 16 (defaults); blk_ready=1 from cycle 16.
//  3. Block handshake at edge T, out_ready=1 -> round_idx 0,1..14 on
//     T+1..T+15, sel_first only at T+1, sel_last only at T+15,
//     out_valid=1 at T+16 for one cycle; FIPS-197 AES-256 vector matches.
//  4. out_ready=0 for 5 cycles after out_valid -> out_valid, round_idx=14
//     stable, state_load=0, blk_ready=0; out_ready=1 -> S_WAIT next cycle.
//  5. key_valid at round_idx=5 -> no out_valid for that block, expand_rst
//     pulse, key_ready back after 16 cycles; key_valid with blk_valid in
//     S_WAIT -> blk_ready=0, block not taken.
//  6. Nr=10, KEY_EXP_CYCLES=11 -> round_idx 0..10, out_valid at T+12.

Source files
------------

// File: rtl/aes_round_sequencer.sv
// Control FSM for the iterative AES encrypt datapath: key expansion,
// then one AddRoundKey-only step plus Nr rounds per accepted block.
module aes_round_sequencer #(
    parameter int unsigned Nr             = 14,
    parameter int unsigned KEY_EXP_CYCLES = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    output logic       key_ready,
    output logic       expand_rst,
    input  logic       blk_valid,
    output logic       blk_ready,
    output logic [3:0] round_idx,
    output logic       sel_first,
    output logic       sel_last,
    output logic       state_load,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy
);
    localparam int unsigned CW = $clog2(KEY_EXP_CYCLES + 1);
    localparam logic [CW-1:0] EXP_LAST = CW'(KEY_EXP_CYCLES - 1);
    localparam logic [3:0] LAST_RND = 4'(Nr);

    typedef enum logic [2:0] {
        S_IDLE,
        S_EXPAND,
        S_WAIT,
        S_ROUND,
        S_HOLD
    } state_t;

    state_t        state, state_n;
    logic [CW-1:0] exp_cnt, exp_cnt_n;
    logic [3:0]    round_idx_n;
    logic          key_ready_n, expand_rst_n;
    logic          sel_first_n, sel_last_n;
    logic          state_load_n, out_valid_n, busy_n;

    // A new key always wins, so a block is never taken in its cycle.
    assign blk_ready = (state == S_WAIT) && !key_valid;

    always_comb begin
        state_n      = state;
        exp_cnt_n    = exp_cnt;
        round_idx_n  = round_idx;
        key_ready_n  = key_ready;
        expand_rst_n = 1'b0;
        sel_first_n  = 1'b0;
        sel_last_n   = 1'b0;
        state_load_n = 1'b0;
        out_valid_n  = 1'b0;
        if (key_valid) begin
            state_n      = S_EXPAND;
            exp_cnt_n    = '0;
            round_idx_n  = 4'd0;
            key_ready_n  = 1'b0;
            expand_rst_n = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    state_n = S_IDLE;
                end
                S_EXPAND: begin
                    if (exp_cnt == EXP_LAST) begin
                        state_n     = S_WAIT;
                        key_ready_n = 1'b1;
                    end else begin
                        exp_cnt_n = exp_cnt + 1'b1;
                    end
                end
                S_WAIT: begin
                    if (blk_valid) begin
                        state_n      = S_ROUND;
                        round_idx_n  = 4'd0;
                        state_load_n = 1'b1;
                        sel_first_n  = 1'b1;
                    end
                end
                S_ROUND: begin
                    if (round_idx == LAST_RND) begin
                        state_n     = S_HOLD;
                        out_valid_n = 1'b1;
                    end else begin
                        round_idx_n  = round_idx + 4'd1;
                        state_load_n = 1'b1;
                        sel_last_n   = (round_idx_n == LAST_RND);
                    end
                end
                S_HOLD: begin
                    if (out_ready) state_n = S_WAIT;
                    else out_valid_n = 1'b1;
                end
                default: begin
                    state_n = S_IDLE;
                end
            endcase
        end
        busy_n = (state_n == S_EXPAND) || (state_n == S_ROUND);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_IDLE;
            exp_cnt    <= '0;
            round_idx  <= 4'd0;
            key_ready  <= 1'b0;
            expand_rst <= 1'b0;
            sel_first  <= 1'b0;
            sel_last   <= 1'b0;
            state_load <= 1'b0;
            out_valid  <= 1'b0;
            busy       <= 1'b0;
        end else begin
            state      <= state_n;
            exp_cnt    <= exp_cnt_n;
            round_idx  <= round_idx_n;
            key_ready  <= key_ready_n;
            expand_rst <= expand_rst_n;
            sel_first  <= sel_first_n;
            sel_last   <= sel_last_n;
            state_load <= state_load_n;
            out_valid  <= out_valid_n;
            busy       <= busy_n;
        end
    end

endmodule
